// File: rtl/sample_history.sv
// Circular history of the last DEPTH accumulated samples with a registered
// tap read port, a running sum and a power-of-two average.
module sample_history #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int IDXW  = $clog2(DEPTH),
    parameter int SUMW  = WIDTH + IDXW
) (
    input  logic             MHz10,
    input  logic             rst,
    input  logic             en,
    input  logic             clear,
    input  logic             store_samp,
    input  logic [WIDTH-1:0] samp_acc,
    input  logic [IDXW-1:0]  rd_idx,
    output logic [WIDTH-1:0] samp_out,
    output logic [WIDTH-1:0] tap_out,
    output logic [SUMW-1:0]  sum_out,
    output logic [WIDTH-1:0] avg_out,
    output logic [IDXW:0]    count,
    output logic             full
);

    localparam logic [IDXW:0] FULL_CNT = (IDXW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [IDXW-1:0]  r_wr_ptr;
    logic [IDXW:0]    r_count;
    logic [SUMW-1:0]  r_sum;
    logic [WIDTH-1:0] r_samp;
    logic [WIDTH-1:0] r_tap;

    logic             w_clr;
    logic             w_push;
    logic [IDXW-1:0]  w_rd_addr;
    logic             w_tap_hit;
    logic [WIDTH-1:0] w_tap_next;
    logic [WIDTH-1:0] w_evict;
    logic [SUMW-1:0]  w_sum_next;
    logic [IDXW:0]    w_cnt_next;

    assign w_clr  = en & clear;
    assign w_push = en & ~clear & store_samp;

    // Tap 0 is the entry just behind the write pointer; indices past the
    // valid count read as zero.
    assign w_rd_addr  = r_wr_ptr - IDXW'(1) - rd_idx;
    assign w_tap_hit  = ({1'b0, rd_idx} < r_count);
    assign w_tap_next = w_tap_hit ? r_mem[w_rd_addr] : '0;

    // The true sum always fits in SUMW bits, so a temporary borrow from the
    // subtraction cancels out under modulo-2^SUMW arithmetic.
    assign w_evict    = r_mem[r_wr_ptr];
    assign w_sum_next = r_sum + SUMW'(samp_acc) - SUMW'(w_evict);
    assign w_cnt_next = (r_count == FULL_CNT) ? r_count : r_count + (IDXW + 1)'(1);

    always_ff @(posedge MHz10) begin
        if (rst || w_clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_sum    <= '0;
            r_samp   <= '0;
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= samp_acc;
            r_wr_ptr        <= r_wr_ptr + IDXW'(1);
            r_count         <= w_cnt_next;
            r_sum           <= w_sum_next;
            r_samp          <= samp_acc;
        end
    end

    // The tap register tracks rd_idx every cycle; only reset clears it.
    always_ff @(posedge MHz10) begin
        if (rst) begin
            r_tap <= '0;
        end else begin
            r_tap <= w_tap_next;
        end
    end

    assign samp_out = r_samp;
    assign tap_out  = r_tap;
    assign sum_out  = r_sum;
    assign avg_out  = r_sum[SUMW-1:IDXW];
    assign count    = r_count;
    assign full     = (r_count == FULL_CNT);

endmodule

// File: tb/tb_sample_history.sv
// Bench for sample_history: directed vector table followed by random traffic
// checked against a queue-based history model.
module tb_sample_history;

  localparam int WIDTH = 16;
  localparam int DEPTH = 8;
  localparam int IDXW  = 3;
  localparam int SUMW  = WIDTH + IDXW;

  // clock/reset block
  logic             MHz10 = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0;
  logic             clear = 1'b0;
  logic             store_samp = 1'b0;
  logic [WIDTH-1:0] samp_acc = '0;
  logic [IDXW-1:0]  rd_idx = '0;
  logic [WIDTH-1:0] samp_out;
  logic [WIDTH-1:0] tap_out;
  logic [SUMW-1:0]  sum_out;
  logic [WIDTH-1:0] avg_out;
  logic [IDXW:0]    count;
  logic             full;

  always #5 MHz10 = ~MHz10;

  sample_history #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .MHz10      (MHz10),
    .rst        (rst),
    .en         (en),
    .clear      (clear),
    .store_samp (store_samp),
    .samp_acc   (samp_acc),
    .rd_idx     (rd_idx),
    .samp_out   (samp_out),
    .tap_out    (tap_out),
    .sum_out    (sum_out),
    .avg_out    (avg_out),
    .count      (count),
    .full       (full)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard model: newest sample at the front of the queue
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] m_tap  = '0;
  logic [WIDTH-1:0] m_samp = '0;

  function automatic void model_edge();
    logic [WIDTH-1:0] t;
    t = (int'(rd_idx) < exp_q.size()) ? exp_q[rd_idx] : '0;
    if (rst) begin
      exp_q.delete();
      m_samp = '0;
      m_tap  = '0;
    end else begin
      m_tap = t;
      if (en && clear) begin
        exp_q.delete();
        m_samp = '0;
      end else if (en && store_samp) begin
        exp_q.push_front(samp_acc);
        if (exp_q.size() > DEPTH) void'(exp_q.pop_back());
        m_samp = samp_acc;
      end
    end
  endfunction

  task automatic check_model();
    longint s;
    s = 0;
    foreach (exp_q[i]) s += exp_q[i];
    chk("model samp_out", 32'(samp_out), 32'(m_samp));
    chk("model tap_out",  32'(tap_out),  32'(m_tap));
    chk("model sum_out",  32'(sum_out),  32'(s));
    chk("model avg_out",  32'(avg_out),  32'(s / DEPTH));
    chk("model count",    32'(count),    32'(exp_q.size()));
    chk("model full",     32'(full),     32'(exp_q.size() == DEPTH));
  endtask

  task automatic tick();
    @(posedge MHz10);
    model_edge();
    #1;
    check_model();
  endtask

  // directed vector table
  typedef struct {
    logic             rst, en, clr, st;
    logic [WIDTH-1:0] samp;
    logic [IDXW-1:0]  rd;
    logic [WIDTH-1:0] e_samp;
    logic [SUMW-1:0]  e_sum;
    logic [IDXW:0]    e_cnt;
    logic [WIDTH-1:0] e_tap;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, input logic e, input logic c, input logic s,
                              input int samp, input int rd, input int es, input int esum,
                              input int ecnt, input int etap);
    vec_t v;
    v.rst = r; v.en = e; v.clr = c; v.st = s;
    v.samp = WIDTH'(samp); v.rd = IDXW'(rd);
    v.e_samp = WIDTH'(es); v.e_sum = SUMW'(esum);
    v.e_cnt = (IDXW + 1)'(ecnt); v.e_tap = WIDTH'(etap);
    vecs.push_back(v);
  endfunction

  initial begin
    int acc;
    // reset then idle
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) add(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    // fill 1..8; tap lags by one entry
    for (int k = 1; k <= 8; k++) add(0, 1, 0, 1, k, 0, k, k * (k + 1) / 2, k, k - 1);
    for (int i = 0; i < 8; i++) add(0, 1, 0, 0, 0, i, 8, 36, 8, 8 - i);
    // wrap and evict the oldest entry
    add(0, 1, 0, 1, 100, 0, 100, 135, 8, 8);
    add(0, 1, 0, 0, 0, 7, 100, 135, 8, 2);
    // clear leaves the tap register to track the pre-edge history
    add(0, 1, 1, 0, 0, 0, 0, 0, 0, 100);
    // partial fill with max-value samples
    add(0, 1, 0, 1, 'hFFFF, 0, 'hFFFF, 'hFFFF, 1, 0);
    add(0, 1, 0, 1, 'hFFFF, 0, 'hFFFF, 'h1FFFE, 2, 'hFFFF);
    add(0, 1, 0, 1, 'hFFFF, 0, 'hFFFF, 'h2FFFD, 3, 'hFFFF);
    add(0, 1, 0, 0, 0, 5, 'hFFFF, 'h2FFFD, 3, 0);
    add(0, 1, 0, 0, 0, 2, 'hFFFF, 'h2FFFD, 3, 'hFFFF);
    // top up to full
    acc = 'h2FFFD;
    for (int j = 0; j < 5; j++) begin
      acc += 16 + j;
      add(0, 1, 0, 1, 16 + j, 0, 16 + j, acc, 4 + j, (j == 0) ? 'hFFFF : 15 + j);
    end
    // clear beats store while full
    add(0, 1, 1, 1, 7, 0, 0, 0, 0, 20);
    for (int i = 0; i < 4; i++) add(0, 0, 0, 1, 55, 0, 0, 0, 0, 0);
    add(0, 1, 0, 1, 3, 0, 3, 3, 1, 0);
    add(0, 0, 1, 0, 0, 0, 3, 3, 1, 3);
    // same-edge read/write
    add(0, 1, 0, 1, 5, 0, 5, 8, 2, 3);
    add(0, 1, 0, 1, 9, 0, 9, 17, 3, 5);
    add(0, 1, 0, 0, 0, 0, 9, 17, 3, 9);
    // reset mid-stream, then the next push starts over
    add(1, 1, 0, 1, 77, 0, 0, 0, 0, 0);
    add(0, 1, 0, 1, 42, 0, 42, 42, 1, 0);
    add(0, 1, 0, 0, 0, 0, 42, 42, 1, 42);

    // driver: apply table
    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst; en = vecs[i].en; clear = vecs[i].clr;
      store_samp = vecs[i].st; samp_acc = vecs[i].samp; rd_idx = vecs[i].rd;
      tick();
      chk($sformatf("vec%0d samp_out", i), 32'(samp_out), 32'(vecs[i].e_samp));
      chk($sformatf("vec%0d sum_out", i),  32'(sum_out),  32'(vecs[i].e_sum));
      chk($sformatf("vec%0d avg_out", i),  32'(avg_out),  32'(vecs[i].e_sum >> IDXW));
      chk($sformatf("vec%0d count", i),    32'(count),    32'(vecs[i].e_cnt));
      chk($sformatf("vec%0d full", i),     32'(full),     32'(vecs[i].e_cnt == (IDXW + 1)'(DEPTH)));
      chk($sformatf("vec%0d tap_out", i),  32'(tap_out),  32'(vecs[i].e_tap));
    end

    // driver: random traffic against the model
    for (int c = 0; c < 600; c++) begin
      rst        = ($urandom_range(0, 99) == 0);
      en         = ($urandom_range(0, 9) != 0);
      clear      = ($urandom_range(0, 39) == 0);
      store_samp = ($urandom_range(0, 3) != 0);
      samp_acc   = ($urandom_range(0, 3) == 0) ? 16'hFFFF : WIDTH'($urandom);
      rd_idx     = IDXW'($urandom_range(0, DEPTH - 1));
      tick();
    end

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
